// File: rtl/sprite_oam_scan_if.sv
// Signal bundle between the OAM scan stage and its environment: the scan
// controls, the OAM read port and the random-access sprite list read port.
// Handshake: start is a single-cycle request pulse; the scanner answers with
// busy for the duration of the walk and a single-cycle done pulse when the
// list is final. There is no back-pressure, and oam_y/oam_x must carry the
// entry that oam_rd_addr named in the previous cycle.
interface sprite_oam_scan_if;
   logic       start;
   logic [7:0] v_cnt;
   logic       size16;
   logic       isGBC;
   logic [5:0] oam_rd_addr;
   logic [7:0] oam_y;
   logic [7:0] oam_x;
   logic       busy;
   logic       done;
   logic [3:0] count;
   logic [3:0] rd_index;
   logic [5:0] rd_idx;
   logic [7:0] rd_x;
   logic       rd_valid;

   // Scanner side
   modport master (
      input  start, v_cnt, size16, isGBC, oam_y, oam_x, rd_index,
      output oam_rd_addr, busy, done, count, rd_idx, rd_x, rd_valid
   );

   // Environment side: line timing, OAM memory and the sprite fetch stage
   modport slave (
      output start, v_cnt, size16, isGBC, oam_y, oam_x, rd_index,
      input  oam_rd_addr, busy, done, count, rd_idx, rd_x, rd_valid
   );
endinterface

// File: rtl/sprite_oam_scan.sv
// Per-line OAM scan: walks the 40 OAM entries, keeps the first 10 whose Y
// range covers the current line and builds the sprite list used by the
// fetch/display stage.
// Optional feature macro: OAM_SCAN_XSORT_EN enables the DMG X-priority
// insertion sort, which applies when isGBC is 0. Without the macro the list
// is always kept in OAM acceptance order.
module sprite_oam_scan (
   input  logic              clk,
   input  logic              reset_n,
   sprite_oam_scan_if.master bus,
   output logic [1:0]        dbg_state
);
   localparam int SPRITES  = 40;
   localparam int MAX_LINE = 10;

   typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, FLUSH = 2'd2} state_t;

   state_t     state_q, state_d;
   logic [5:0] ptr_q, ptr_d;
   logic [3:0] count_q, count_d;
   logic [7:0] v_cnt_q, v_cnt_d;
   logic       size16_q, size16_d;
   logic       gbc_q, gbc_d;
   logic       done_q, done_d;
   logic [5:0] slot_idx_q [MAX_LINE];
   logic [5:0] slot_idx_d [MAX_LINE];
   logic [7:0] slot_x_q [MAX_LINE];
   logic [7:0] slot_x_d [MAX_LINE];

   logic       eval_en;
   logic [5:0] eval_idx;
   logic [8:0] diff;
   logic       visible;
   logic [3:0] ins_pos;

   // Judge the entry whose OAM bytes arrive this cycle (read issued last cycle)
   always_comb begin
      eval_en  = ((state_q == SCAN) && (ptr_q != 6'd0)) || (state_q == FLUSH);
      eval_idx = (state_q == FLUSH) ? 6'(SPRITES - 1) : ptr_q - 6'd1;
      diff     = {1'b0, v_cnt_q} + 9'd16 - {1'b0, bus.oam_y};
      visible  = !diff[8] && (diff < (size16_q ? 9'd16 : 9'd8));
   end

   // Slot the new entry lands in: after every kept slot with x <= new x
   always_comb begin
      ins_pos = count_q;
`ifdef OAM_SCAN_XSORT_EN
      if (!gbc_q) begin
         ins_pos = 4'd0;
         for (int i = 0; i < MAX_LINE; i++) begin
            if ((4'(i) < count_q) && (slot_x_q[i] <= bus.oam_x)) begin
               ins_pos = ins_pos + 4'd1;
            end
         end
      end
`endif
   end

`ifndef OAM_SCAN_XSORT_EN
   // The CGB flag only matters to the sort; keep it observable for the build
   logic unused_gbc;
   assign unused_gbc = gbc_q;
`endif

   // Next-state, pointer, counter and list update; start overrides everything
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      count_d    = count_q;
      v_cnt_d    = v_cnt_q;
      size16_d   = size16_q;
      gbc_d      = gbc_q;
      done_d     = 1'b0;
      slot_idx_d = slot_idx_q;
      slot_x_d   = slot_x_q;

      case (state_q)
         IDLE: begin
         end
         SCAN: begin
            if (ptr_q == 6'(SPRITES - 1)) state_d = FLUSH;
            else                          ptr_d   = ptr_q + 6'd1;
         end
         FLUSH: begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      if (eval_en && visible && (count_q < 4'(MAX_LINE))) begin
         for (int i = MAX_LINE - 1; i >= 1; i--) begin
            if (4'(i) > ins_pos) begin
               slot_idx_d[i] = slot_idx_q[i-1];
               slot_x_d[i]   = slot_x_q[i-1];
            end else if (4'(i) == ins_pos) begin
               slot_idx_d[i] = eval_idx;
               slot_x_d[i]   = bus.oam_x;
            end
         end
         if (ins_pos == 4'd0) begin
            slot_idx_d[0] = eval_idx;
            slot_x_d[0]   = bus.oam_x;
         end
         count_d = count_q + 4'd1;
      end

      if (bus.start) begin
         state_d  = SCAN;
         ptr_d    = 6'd0;
         count_d  = 4'd0;
         v_cnt_d  = bus.v_cnt;
         size16_d = bus.size16;
         gbc_d    = bus.isGBC;
         done_d   = 1'b0;
         for (int i = 0; i < MAX_LINE; i++) begin
            slot_idx_d[i] = 6'd0;
            slot_x_d[i]   = 8'hFF;
         end
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         ptr_q    <= 6'd0;
         count_q  <= 4'd0;
         v_cnt_q  <= 8'd0;
         size16_q <= 1'b0;
         gbc_q    <= 1'b0;
         done_q   <= 1'b0;
         for (int i = 0; i < MAX_LINE; i++) begin
            slot_idx_q[i] <= 6'd0;
            slot_x_q[i]   <= 8'hFF;
         end
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         count_q    <= count_d;
         v_cnt_q    <= v_cnt_d;
         size16_q   <= size16_d;
         gbc_q      <= gbc_d;
         done_q     <= done_d;
         slot_idx_q <= slot_idx_d;
         slot_x_q   <= slot_x_d;
      end
   end

   // Random-access list read; empty and out-of-range slots read as cleared
   always_comb begin
      bus.rd_valid = 1'b0;
      bus.rd_idx   = 6'd0;
      bus.rd_x     = 8'hFF;
      for (int i = 0; i < MAX_LINE; i++) begin
         if ((4'(i) == bus.rd_index) && (4'(i) < count_q)) begin
            bus.rd_valid = 1'b1;
            bus.rd_idx   = slot_idx_q[i];
            bus.rd_x     = slot_x_q[i];
         end
      end
   end

   assign bus.oam_rd_addr = ptr_q;
   assign bus.busy        = (state_q != IDLE);
   assign bus.done        = done_q;
   assign bus.count       = count_q;
   assign dbg_state       = state_q;
endmodule
